// File: rtl/sram_rr_arbiter_if.sv
// One requester's access port into the SRAM arbiter.
interface sram_rr_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;

    // Requester side drives the request, arbiter drives grant/rvalid.
    modport master (output req, we, addr, wdata, input gnt, rvalid);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid);
endinterface

// File: rtl/sram_rr_arbiter.sv
// Two-requester round-robin arbiter in front of a 1R1W synchronous SRAM.
// One access per cycle; a requester may hold the SRAM for up to MAX_BURST
// consecutive grants while the other one waits. Read data comes straight
// from the SRAM and is tagged with a per-requester valid strobe.
module sram_rr_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    sram_rr_arbiter_if.slave  rq0_if,
    sram_rr_arbiter_if.slave  rq1_if,
    output logic [DATA_W-1:0] rdata_o,
    output logic [ADDR_W-1:0] sram_raddr_o,
    output logic [ADDR_W-1:0] sram_waddr_o,
    output logic [DATA_W-1:0] sram_wdata_o,
    output logic              sram_wen_o,
    input  logic [DATA_W-1:0] sram_rdata_i
);
    // Keep the counter at least one bit wide so MAX_BURST=1 still elaborates.
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {OWN_NONE, OWN_R0, OWN_R1} owner_t;

    owner_t           owner_q, owner_d;
    logic [CNT_W-1:0] burst_q, burst_d;
    logic             rr_q, rr_d;        // 0: requester 0 next, 1: requester 1 next
    logic             rvalid0_q, rvalid0_d;
    logic             rvalid1_q, rvalid1_d;
    logic             gnt0, gnt1;

    // State register: ownership, burst length, round-robin pointer, read strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q   <= OWN_NONE;
            burst_q   <= '0;
            rr_q      <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            burst_q   <= burst_d;
            rr_q      <= rr_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    // Next state: extend or hand over ownership depending on who was granted.
    always_comb begin
        owner_d   = OWN_NONE;
        burst_d   = '0;
        rr_d      = rr_q;
        rvalid0_d = gnt0 & ~rq0_if.we;
        rvalid1_d = gnt1 & ~rq1_if.we;
        if (gnt0) begin
            owner_d = OWN_R0;
            rr_d    = 1'b1;
            if (owner_q == OWN_R0)
                burst_d = (burst_q == LAST) ? LAST : burst_q + 1'b1;
        end else if (gnt1) begin
            owner_d = OWN_R1;
            rr_d    = 1'b0;
            if (owner_q == OWN_R1)
                burst_d = (burst_q == LAST) ? LAST : burst_q + 1'b1;
        end
    end

    // Grant decode: a lone requester always wins; under contention the
    // current owner keeps the SRAM until its burst is used up.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (rq0_if.req && !rq1_if.req) begin
                gnt0 = 1'b1;
            end else if (rq1_if.req && !rq0_if.req) begin
                gnt1 = 1'b1;
            end else if (rq0_if.req && rq1_if.req) begin
                case (owner_q)
                    OWN_R0:  if (burst_q == LAST) gnt1 = 1'b1; else gnt0 = 1'b1;
                    OWN_R1:  if (burst_q == LAST) gnt0 = 1'b1; else gnt1 = 1'b1;
                    default: if (rr_q) gnt1 = 1'b1; else gnt0 = 1'b1;
                endcase
            end
        end
    end

    // SRAM drive: steer the granted requester's access, idle to zero.
    always_comb begin
        sram_raddr_o = '0;
        sram_wdata_o = '0;
        sram_wen_o   = 1'b0;
        if (gnt0) begin
            sram_raddr_o = rq0_if.addr;
            sram_wdata_o = rq0_if.wdata;
            sram_wen_o   = rq0_if.we;
        end else if (gnt1) begin
            sram_raddr_o = rq1_if.addr;
            sram_wdata_o = rq1_if.wdata;
            sram_wen_o   = rq1_if.we;
        end
    end

    assign sram_waddr_o  = sram_raddr_o;
    assign rdata_o       = sram_rdata_i;
    assign rq0_if.gnt    = gnt0;
    assign rq1_if.gnt    = gnt1;
    assign rq0_if.rvalid = rvalid0_q;
    assign rq1_if.rvalid = rvalid1_q;
endmodule

// File: doc/sram_rr_arbiter.md
Name: sram_rr_arbiter

Overview:
- Two-requester arbiter sharing the sort SRAM (32-bit data, 10-bit address, 1024 words).
- The SRAM has a synchronous read port, a synchronous write port and 1-cycle read latency.
- Typical requesters: requester 0 is the bubble-sort engine, requester 1 is the host loader/checker.
- Grants one access (read or write) per cycle. Round-robin between requesters with bounded burst ownership. Routes read data back with a per-requester valid strobe.

Parameters:
- DATA_W, 32, data width
- ADDR_W, 10, address width
- MAX_BURST, 4, max consecutive grants to one requester while the other is requesting (≥1)

Ports:
- clk  in  1  clock, all registers on posedge
- rst  in  1  synchronous reset, active-high
- req0  in  1  requester 0 access request
- we0  in  1  requester 0: 1 = write, 0 = read
- addr0  in  ADDR_W  requester 0 address
- wdata0  in  DATA_W  requester 0 write data
- gnt0  out  1  requester 0 grant (combinational)
- rvalid0  out  1  requester 0 read data valid on rdata
- req1/we1/addr1/wdata1/gnt1/rvalid1  as above, requester 1
- rdata  out  DATA_W  read data, shared by both requesters
- sram_raddr  out  ADDR_W  to SRAM RAddr
- sram_waddr  out  ADDR_W  to SRAM WAddr
- sram_wdata  out  DATA_W  to SRAM WData
- sram_wen  out  1  to SRAM Wen
- sram_rdata  in  DATA_W  from SRAM RData

Behaviour:
Registered state:
- owner ∈ {NONE, R0, R1}: requester granted last cycle.
- burst_cnt (clog2(MAX_BURST) bits): consecutive grants to owner, minus 1.
- rr_ptr: next-priority requester when neither requester holds ownership.
- rvalid0, rvalid1.

Reset:
- On a posedge with rst=1: owner=NONE, burst_cnt=0, rr_ptr=0, rvalid0=rvalid1=0.
- While rst=1: gnt0=gnt1=0 and sram_wen=0 (combinationally forced).

Grant (combinational, at most one of gnt0/gnt1 high):
- Only one req high → grant it.
- Both high, owner=Rk, burst_cnt<MAX_BURST-1 → grant Rk (continue burst).
- Both high, owner=Rk, burst_cnt=MAX_BURST-1 → grant the other requester.
- Both high, owner=NONE → grant rr_ptr.
- No req → no grant.

Handshake:
- Requester holds req/we/addr/wdata stable until it samples gnt=1 at a posedge; the access completes at that edge.
- Dropping req without a grant is legal (request withdrawn).

State update each non-reset edge:
- Grant to Rk with owner=Rk → burst_cnt+1 (saturating at MAX_BURST-1).
- Grant to Rk with owner≠Rk → owner=Rk, burst_cnt=0.
- Any grant to Rk → rr_ptr = other requester.
- No grant → owner=NONE, burst_cnt=0, rr_ptr unchanged.

SRAM drive:
- sram_raddr = sram_waddr = granted addr; 0 when no grant.
- sram_wdata = granted wdata; 0 when no grant.
- sram_wen = grant & granted we.

Read return:
- rvalid_k <= gnt_k & ~we_k. rvalid_k is high in the cycle after the grant edge.
- rdata = sram_rdata (passthrough). It is valid exactly when an rvalid is high.
- At most one rvalid is high per cycle.

Boundaries:
- MAX_BURST=1 → strict alternation under contention.
- A write then a read of the same address on consecutive grants returns the new data.
- Reset mid-burst: ownership is lost, and any rvalid pending from the cycle before reset is dropped (0 after the reset edge).
- addr wraps naturally at 2^ADDR_W (no range check).

Test Plan:
- Reset: hold rst=1 for 2 cycles with req0=req1=1 → gnt0=gnt1=0 and sram_wen=0 throughout; rvalid0=rvalid1=0 after the first reset edge.
- Single write/read: req0 writes 0x0000_00AB to addr 5, then reads addr 5 → gnt0=1 in both cycles; sram_wen=1 only in the first; rvalid0=1 one cycle after the read grant with rdata=0x0000_00AB.
- Contention, MAX_BURST=4: both requests held for 12 cycles starting with owner=NONE, rr_ptr=0 → grant sequence 0,0,0,0,1,1,1,1,0,0,0,0.
- Solo burst: req1 alone for 10 cycles → gnt1=1 in all 10 cycles (burst limit applies only under contention).
- Read routing: req0 reads addr 3 (value 7) in cycle N; req1 reads addr 4 (value 9) in cycle N+1 → rvalid0=1 with rdata=7 at N+1; rvalid1=1 with rdata=9 at N+2; never both high.
- Reset mid-burst: assert rst on the 3rd cycle of a req0 burst under contention → after reset, both requests held → gnt0 first (rr_ptr=0), and the full 4-grant burst is restored.
